// File: rtl/sc_shift_sequencer.sv
//------------------------------------------------------------------------------
// sc_shift_sequencer
// Sequences one shift command: source onto BUSA, load the shifter, shift N
// times, then write the result to a general register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sc_shift_sequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_COUNT                = 4
) (
  input  logic                                      SC_SHIFTSEQ_CLOCK_50,
  input  logic                                      SC_SHIFTSEQ_Reset_InHigh,
  input  logic                                      SC_SHIFTSEQ_Start_InHigh,
  input  logic [2:0]                                SC_SHIFTSEQ_Src_In,
  input  logic [2:0]                                SC_SHIFTSEQ_Dst_In,
  input  logic                                      SC_SHIFTSEQ_Dir_In,
  input  logic [DATAWIDTH_COUNT-1:0]                SC_SHIFTSEQ_Count_In,
  input  logic                                      SC_SHIFTSEQ_Abort_InHigh,
  output logic                                      SC_SHIFTSEQ_Ready_Out,
  output logic                                      SC_SHIFTSEQ_Done_Out,
  output logic                                      SC_SHIFTSEQ_Error_Out,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_SHIFTSEQ_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTSEQ_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTSEQ_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_SHIFTSEQ_ALUSelection_Out,
  output logic                                      SC_SHIFTSEQ_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_SEL = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] c_SHIFT_LEFT  =
    DATAWIDTH_REGSHIFTER_SELECTION'(1);
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] c_SHIFT_RIGHT =
    DATAWIDTH_REGSHIFTER_SELECTION'(2);

  state_t                     state_q, state_d;
  logic [2:0]                 src_q, src_d;
  logic [2:0]                 dst_q, dst_d;
  logic                       dir_q, dir_d;
  logic [DATAWIDTH_COUNT-1:0] count_q, count_d;
  logic [DATAWIDTH_COUNT-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       w_cmd_illegal;

  // Sources 110/111 have no register behind them; only RegGen_0..3 are writable.
  assign w_cmd_illegal = (SC_SHIFTSEQ_Src_In[2] & SC_SHIFTSEQ_Src_In[1]) | SC_SHIFTSEQ_Dst_In[2];

  always_ff @(posedge SC_SHIFTSEQ_CLOCK_50) begin
    if (SC_SHIFTSEQ_Reset_InHigh) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dir_d   = dir_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    SC_SHIFTSEQ_DecoderSelectionWrite_Out       = '1;
    SC_SHIFTSEQ_MUXSelectionBUSA_Out            = '1;
    SC_SHIFTSEQ_MUXSelectionBUSB_Out            = '1;
    SC_SHIFTSEQ_ALUSelection_Out                = '1;
    SC_SHIFTSEQ_RegSHIFTERLoad_OutLow           = 1'b1;
    SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow = '1;

    case (state_q)
      ST_IDLE: begin
        if (SC_SHIFTSEQ_Start_InHigh) begin
          if (w_cmd_illegal) begin
            err_d = 1'b1;
          end else begin
            src_d   = SC_SHIFTSEQ_Src_In;
            dst_d   = SC_SHIFTSEQ_Dst_In;
            dir_d   = SC_SHIFTSEQ_Dir_In;
            count_d = SC_SHIFTSEQ_Count_In;
            state_d = ST_LOAD_SEL;
          end
        end
      end

      ST_LOAD_SEL: begin
        SC_SHIFTSEQ_MUXSelectionBUSA_Out = DATAWIDTH_MUX_SELECTION'(src_q);
        SC_SHIFTSEQ_ALUSelection_Out     = '0;
        state_d = SC_SHIFTSEQ_Abort_InHigh ? ST_IDLE : ST_LOAD;
      end

      ST_LOAD: begin
        SC_SHIFTSEQ_MUXSelectionBUSA_Out  = DATAWIDTH_MUX_SELECTION'(src_q);
        SC_SHIFTSEQ_ALUSelection_Out      = '0;
        SC_SHIFTSEQ_RegSHIFTERLoad_OutLow = 1'b0;
        if (SC_SHIFTSEQ_Abort_InHigh) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d   = count_q;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow = dir_q ? c_SHIFT_RIGHT : c_SHIFT_LEFT;
        if (SC_SHIFTSEQ_Abort_InHigh) begin
          state_d = ST_IDLE;
        end else begin
          // Saturating decrement; the exit on value 1 keeps it from ever reaching a wrap.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DATAWIDTH_COUNT'(1);
          end
          if (cnt_q <= DATAWIDTH_COUNT'(1)) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        SC_SHIFTSEQ_DecoderSelectionWrite_Out = DATAWIDTH_DECODER_SELECTION'(dst_q);
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign SC_SHIFTSEQ_Ready_Out = (state_q == ST_IDLE);
  assign SC_SHIFTSEQ_Done_Out  = (state_q == ST_DONE);
  assign SC_SHIFTSEQ_Error_Out = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sc_shift_sequencer.sv
//------------------------------------------------------------------------------
// tb_sc_shift_sequencer
// Directed self-checking bench for sc_shift_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sc_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] src;
  logic [2:0] dst;
  logic       dir;
  logic [3:0] count;
  logic       abort;

  logic       ready, done, err;
  logic [2:0] dec, busa, busb;
  logic [3:0] alu;
  logic       load_n;
  logic [1:0] shift_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sc_shift_sequencer dut (
    .SC_SHIFTSEQ_CLOCK_50                        (clk),
    .SC_SHIFTSEQ_Reset_InHigh                    (rst),
    .SC_SHIFTSEQ_Start_InHigh                    (start),
    .SC_SHIFTSEQ_Src_In                          (src),
    .SC_SHIFTSEQ_Dst_In                          (dst),
    .SC_SHIFTSEQ_Dir_In                          (dir),
    .SC_SHIFTSEQ_Count_In                        (count),
    .SC_SHIFTSEQ_Abort_InHigh                    (abort),
    .SC_SHIFTSEQ_Ready_Out                       (ready),
    .SC_SHIFTSEQ_Done_Out                        (done),
    .SC_SHIFTSEQ_Error_Out                       (err),
    .SC_SHIFTSEQ_DecoderSelectionWrite_Out       (dec),
    .SC_SHIFTSEQ_MUXSelectionBUSA_Out            (busa),
    .SC_SHIFTSEQ_MUXSelectionBUSB_Out            (busb),
    .SC_SHIFTSEQ_ALUSelection_Out                (alu),
    .SC_SHIFTSEQ_RegSHIFTERLoad_OutLow           (load_n),
    .SC_SHIFTSEQ_RegSHIFTERShiftSelection_OutLow (shift_n)
  );

  logic [15:0] w_cw;
  logic [2:0]  w_st;
  assign w_cw = {dec, busa, busb, alu, load_n, shift_n};
  assign w_st = {ready, done, err};

  localparam logic [15:0] c_IDLE_CW = 16'hFFFF;

  function automatic logic [15:0] cw(input logic [2:0] d, input logic [2:0] a,
                                     input logic [3:0] op, input logic ld,
                                     input logic [1:0] sh);
    return {d, a, 3'b111, op, ld, sh};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts a command, then watches up to max_cyc cycles after the accepting edge.
  task automatic run_cmd(input logic [2:0] s, input logic [2:0] d, input logic dr,
                         input logic [3:0] n, input int abort_cyc, input int max_cyc,
                         output int n_shift, output int n_write, output int done_cyc,
                         output int ready_cyc, output int n_err, output logic [1:0] sh_seen);
    n_shift = 0; n_write = 0; done_cyc = 0; ready_cyc = 0; n_err = 0; sh_seen = 2'b11;
    src = s; dst = d; dir = dr; count = n; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (shift_n != 2'b11) begin n_shift++; sh_seen = shift_n; end
      if (dec != 3'b111) n_write++;
      if (done && done_cyc == 0) done_cyc = c;
      if (ready && ready_cyc == 0) ready_cyc = c;
      if (err) n_err++;
      abort = (c == abort_cyc);
      // A stray illegal Start while busy must be ignored with no Error pulse.
      start = (c == 2);
      src   = (c == 2) ? 3'b110 : s;
      tick();
    end
    abort = 1'b0; start = 1'b0; src = s;
  endtask

  int          ns, nw, dc, rc, ne;
  logic [1:0]  shs;

  initial begin
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; dir = 1'b0; count = '0; abort = 1'b0;
    tick(); tick();
    check("reset_cw", w_cw, c_IDLE_CW);
    check("reset_status", w_st, 3'b100);
    rst = 1'b0;
    tick();

    // Src=101 Dst=010 left Count=1, cycle by cycle
    src = 3'b101; dst = 3'b010; dir = 1'b0; count = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("c1_loadsel_cw", w_cw, cw(3'b111, 3'b101, 4'b0000, 1'b1, 2'b11));
    check("c1_status", w_st, 3'b000);
    tick();
    check("c2_load_cw", w_cw, cw(3'b111, 3'b101, 4'b0000, 1'b0, 2'b11));
    tick();
    check("c3_shift_cw", w_cw, cw(3'b111, 3'b111, 4'b1111, 1'b1, 2'b01));
    tick();
    check("c4_write_cw", w_cw, cw(3'b010, 3'b111, 4'b1111, 1'b1, 2'b11));
    tick();
    check("c5_done_cw", w_cw, c_IDLE_CW);
    check("c5_status", w_st, 3'b010);
    tick();
    check("c6_status", w_st, 3'b100);

    // Src=000 Dst=011 right Count=15
    run_cmd(3'b000, 3'b011, 1'b1, 4'd15, 0, 22, ns, nw, dc, rc, ne, shs);
    check("c15_shift_cycles", ns, 15);
    check("c15_shift_dir", shs, 2'b10);
    check("c15_done_cycle", dc, 19);
    check("c15_ready_cycle", rc, 20);
    check("c15_write_cycles", nw, 1);
    check("c15_no_error", ne, 0);

    // Count=0 skips SHIFT
    run_cmd(3'b001, 3'b000, 1'b0, 4'd0, 0, 6, ns, nw, dc, rc, ne, shs);
    check("c0_shift_cycles", ns, 0);
    check("c0_done_cycle", dc, 4);
    check("c0_write_cycles", nw, 1);

    // Abort during WRITE is ignored
    run_cmd(3'b100, 3'b001, 1'b0, 4'd0, 3, 6, ns, nw, dc, rc, ne, shs);
    check("abort_write_done", dc, 4);

    // Illegal commands
    src = 3'b110; dst = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_src_status", w_st, 3'b101);
    check("err_src_cw", w_cw, c_IDLE_CW);
    tick();
    check("err_src_clear", w_st, 3'b100);
    src = 3'b010; dst = 3'b100; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_dst_status", w_st, 3'b101);
    check("err_dst_cw", w_cw, c_IDLE_CW);
    tick();
    check("err_dst_clear", w_st, 3'b100);

    // Abort in 3rd SHIFT cycle of Count=8
    run_cmd(3'b011, 3'b010, 1'b0, 4'd8, 5, 14, ns, nw, dc, rc, ne, shs);
    check("abort_shift_cycles", ns, 3);
    check("abort_ready_cycle", rc, 6);
    check("abort_no_write", nw, 0);
    check("abort_no_done", dc, 0);

    // Reset during SHIFT with Start held high
    src = 3'b001; dst = 3'b011; dir = 1'b1; count = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rst_pre_shift", w_cw, cw(3'b111, 3'b111, 4'b1111, 1'b1, 2'b10));
    rst = 1'b1; start = 1'b1;
    tick();
    check("rst_cw", w_cw, c_IDLE_CW);
    check("rst_status", w_st, 3'b100);
    rst = 1'b0;
    tick();
    start = 1'b0;
    check("rst_accept_cw", w_cw, cw(3'b111, 3'b001, 4'b0000, 1'b1, 2'b11));
    dc = 0;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (done && dc == 0) dc = c;
    end
    check("rst_accept_done", dc, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
